timer_bank: RTL and testbench



---
 rtl/timer_bank.sv | 181 ++++++++++++++++++
 tb/tb_timer_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// timer_bank: NCH-channel memory-mapped timer on the picorv32 native memory bus.
// Each channel: WIDTH-bit up-counter with prescaler, one-shot/auto-reload, W1C interrupt.
module timer_bank #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NCH       = 2,
  parameter int          WIDTH     = 32,
  parameter int          PW        = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           mem_valid,
  input  logic [31:0]    mem_addr,
  input  logic [31:0]    mem_wdata,
  input  logic [3:0]     mem_wstrb,
  output logic [31:0]    mem_rdata,
  output logic           mem_ready,
  output logic [NCH-1:0] irq,
  output logic           irq_any
);
  localparam int         CW        = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_LOAD  = 2'd1;
  localparam logic [1:0] REG_COUNT = 2'd2;
  localparam logic [1:0] REG_PRESC = 2'd3;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic                      r_ready;
  logic [31:0]               r_rdata;
  logic [31:0]               w_off;
  logic [31:0]               w_mask;
  logic [31:0]               w_rd_val;
  logic                      w_hit;
  logic                      w_we;
  logic [CW-1:0]             w_ch;
  logic [1:0]                w_reg;
  logic [NCH-1:0][4:0]       w_ctrl;
  logic [NCH-1:0][WIDTH-1:0] w_load;
  logic [NCH-1:0][WIDTH-1:0] w_count;
  logic [NCH-1:0][PW-1:0]    w_presc;

  // Offset subtraction wraps addresses below BASE_ADDR to huge values, so one compare bounds the window.
  assign w_off  = mem_addr - BASE_ADDR;
  assign w_hit  = mem_valid && !r_ready && (w_off < 32'(16 * NCH));
  assign w_we   = w_hit && (mem_wstrb != 4'b0000);
  assign w_ch   = w_off[4 +: CW];
  assign w_reg  = w_off[3:2];
  assign w_mask = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};

  always_comb begin
    w_rd_val = 32'h0;
    case (w_reg)
      REG_CTRL:  w_rd_val = 32'(w_ctrl[w_ch]);
      REG_LOAD:  w_rd_val = 32'(w_load[w_ch]);
      REG_COUNT: w_rd_val = 32'(w_count[w_ch]);
      REG_PRESC: w_rd_val = 32'(w_presc[w_ch]);
      default:   w_rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_ready <= w_hit;
      if (w_hit) r_rdata <= w_rd_val;
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign irq_any   = |irq;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    state_t           r_state, w_state_next;
    logic             r_int, r_go, r_en, r_auto, r_ie;
    logic             w_int_next, w_go_next, w_en_next, w_auto_next, w_ie_next;
    logic [WIDTH-1:0] r_load, r_count, w_load_next, w_count_next;
    logic [PW-1:0]    r_presc, r_pre, w_presc_next, w_pre_next;
    logic             w_sel;

    assign w_sel = w_we && (w_ch == CW'(gi));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= S_IDLE;
        r_int   <= 1'b0;
        r_go    <= 1'b0;
        r_en    <= 1'b0;
        r_auto  <= 1'b0;
        r_ie    <= 1'b0;
        r_load  <= '0;
        r_count <= '0;
        r_presc <= '0;
        r_pre   <= '0;
      end else begin
        r_state <= w_state_next;
        r_int   <= w_int_next;
        r_go    <= w_go_next;
        r_en    <= w_en_next;
        r_auto  <= w_auto_next;
        r_ie    <= w_ie_next;
        r_load  <= w_load_next;
        r_count <= w_count_next;
        r_presc <= w_presc_next;
        r_pre   <= w_pre_next;
      end
    end

    // Software writes first; the counter logic below overrides INT/GO so hardware wins collisions.
    always_comb begin
      w_state_next = r_state;
      w_int_next   = r_int;
      w_go_next    = r_go;
      w_en_next    = r_en;
      w_auto_next  = r_auto;
      w_ie_next    = r_ie;
      w_load_next  = r_load;
      w_count_next = r_count;
      w_presc_next = r_presc;
      w_pre_next   = r_pre;

      if (w_sel && (w_reg == REG_CTRL) && mem_wstrb[0]) begin
        if (mem_wdata[0]) w_int_next = 1'b0;
        w_go_next   = mem_wdata[1];
        w_en_next   = mem_wdata[2];
        w_auto_next = mem_wdata[3];
        w_ie_next   = mem_wdata[4];
      end
      if (w_sel && (w_reg == REG_LOAD))
        w_load_next = WIDTH'((32'(r_load) & ~w_mask) | (mem_wdata & w_mask));
      if (w_sel && (w_reg == REG_PRESC))
        w_presc_next = PW'((32'(r_presc) & ~w_mask) | (mem_wdata & w_mask));

      case (r_state)
        S_IDLE: begin
          if (r_go && r_en) begin
            w_state_next = S_RUN;
            w_count_next = r_load;
            w_pre_next   = '0;
          end else if (!r_en) begin
            w_pre_next = '0;
          end
        end
        S_RUN: begin
          if (!(r_go && r_en)) begin
            w_state_next = S_IDLE;
            if (!r_en) w_pre_next = '0;
          end else if (r_pre == r_presc) begin
            w_pre_next = '0;
            if (&r_count) begin
              w_int_next = 1'b1;
              if (r_auto) begin
                w_count_next = r_load;
              end else begin
                w_count_next = '0;
                w_go_next    = 1'b0;
                w_state_next = S_IDLE;
              end
            end else begin
              w_count_next = r_count + 1'b1;
            end
          end else begin
            w_pre_next = r_pre + 1'b1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase

      if (!w_en_next) w_go_next = 1'b0;
    end

    assign w_ctrl[gi]  = {r_ie, r_auto, r_en, r_go, r_int};
    assign w_load[gi]  = r_load;
    assign w_count[gi] = r_count;
    assign w_presc[gi] = r_presc;
    assign irq[gi]     = r_int & r_ie;
  end

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank (WIDTH=8, NCH=2); read expectations go through a scoreboard queue.
module tb_timer_bank;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          NCH   = 2;
  localparam int          WIDTH = 8;
  localparam int          PW    = 16;
  localparam int R_CTRL = 0, R_LOAD = 1, R_COUNT = 2, R_PRESC = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           mem_valid = 1'b0;
  logic [31:0]    mem_addr = 32'h0;
  logic [31:0]    mem_wdata = 32'h0;
  logic [3:0]     mem_wstrb = 4'h0;
  logic [31:0]    mem_rdata;
  logic           mem_ready;
  logic [NCH-1:0] irq;
  logic           irq_any;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  timer_bank #(.BASE_ADDR(BASE), .NCH(NCH), .WIDTH(WIDTH), .PW(PW)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .irq(irq), .irq_any(irq_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ra(input int ch, input int r);
    return BASE + 32'(16 * ch + 4 * r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) step();
  endtask

  // One bus access; returns one cycle after the acknowledge edge, with mem_ready low again.
  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                     output logic [31:0] rdata, output int ack);
    int issue;
    bit got;
    issue = cyc;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    got   = 1'b0;
    ack   = -1;
    rdata = 32'h0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (mem_ready) begin
        got   = 1'b1;
        ack   = cyc;
        rdata = mem_rdata;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    check("ack_latency", 32'(ack), 32'(issue + 1));
    step();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    output int ack);
    logic [31:0] d;
    bus(addr, data, strb, d, ack);
  endtask

  task automatic rd_check(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    int a;
    sb_t e;
    sb_q.push_back('{tag: tag, exp: exp});
    bus(addr, 32'h0, 4'h0, d, a);
    e = sb_q.pop_front();
    check(e.tag, d, e.exp);
  endtask

  initial begin
    int t;
    int t1;
    int a;

    // Reset state
    repeat (3) step();
    check("rst_ready", 32'(mem_ready), 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_irq_any", 32'(irq_any), 32'h0);
    reset = 1'b0;
    step();
    for (int ch = 0; ch < NCH; ch++)
      for (int r = 0; r < 4; r++)
        rd_check(ra(ch, r), 32'h0, $sformatf("rst_reg_ch%0d_r%0d", ch, r));

    // One-shot, PRESC=0: LOAD=FC counts FC,FD,FE,FF then overflows
    wr(ra(0, R_LOAD), 32'hFC, 4'hF, a);
    wr(ra(0, R_CTRL), 32'h06, 4'h1, t);
    rd_check(ra(0, R_COUNT), 32'hFC, "os_cnt_fc");
    rd_check(ra(0, R_COUNT), 32'hFE, "os_cnt_fe");
    check("os_irq_masked", 32'(irq), 32'h0);
    rd_check(ra(0, R_CTRL), 32'h05, "os_ctrl_int_go0");
    rd_check(ra(0, R_COUNT), 32'h00, "os_cnt_zero");
    wr(ra(0, R_CTRL), 32'h17, 4'h1, t);
    step();
    rd_check(ra(0, R_COUNT), 32'hFD, "os2_cnt_fd");
    check("os2_int_cleared", 32'(irq), 32'h0);
    rd_check(ra(0, R_COUNT), 32'hFF, "os2_cnt_ff");
    check("os2_irq_rise", 32'(irq), 32'h1);
    check("os2_irq_any", 32'(irq_any), 32'h1);
    wr(ra(0, R_CTRL), 32'h01, 4'h1, a);
    check("os2_irq_clr", 32'(irq), 32'h0);
    check("os2_irq_any_clr", 32'(irq_any), 32'h0);

    // Auto-reload, LOAD=FE PRESC=2: overflow every 6 cycles; W1C on overflow edge loses
    wr(ra(0, R_LOAD), 32'hFE, 4'hF, a);
    wr(ra(0, R_PRESC), 32'h2, 4'hF, a);
    wr(ra(0, R_CTRL), 32'h0E, 4'h1, t);
    wait_until(t + 8);
    wr(ra(0, R_CTRL), 32'h0F, 4'h1, a);
    rd_check(ra(0, R_CTRL), 32'h0E, "ar_w1c_between");
    wr(ra(0, R_CTRL), 32'h0F, 4'h1, a);
    rd_check(ra(0, R_CTRL), 32'h0F, "ar_hw_set_wins");
    rd_check(ra(0, R_COUNT), 32'hFF, "ar_cnt_ff_a");
    rd_check(ra(0, R_COUNT), 32'hFF, "ar_cnt_ff_b");
    rd_check(ra(0, R_COUNT), 32'hFE, "ar_cnt_reload");
    wr(ra(0, R_CTRL), 32'h01, 4'h1, a);

    // Independence: same LOAD, ch1 prescaled by 4
    wr(ra(0, R_LOAD), 32'hF0, 4'hF, a);
    wr(ra(0, R_PRESC), 32'h0, 4'hF, a);
    wr(ra(1, R_LOAD), 32'hF0, 4'hF, a);
    wr(ra(1, R_PRESC), 32'h3, 4'hF, a);
    wr(ra(0, R_CTRL), 32'h16, 4'h1, t);
    wr(ra(1, R_CTRL), 32'h16, 4'h1, t1);
    wait_until(t + 16);
    check("ind_ch0_before", 32'(irq), 32'h0);
    step();
    check("ind_ch0_ovf", 32'(irq), 32'h1);
    wait_until(t1 + 64);
    check("ind_ch1_before", 32'(irq), 32'h1);
    step();
    check("ind_ch1_ovf", 32'(irq), 32'h3);
    check("ind_any", 32'(irq_any), 32'h1);
    wr(ra(0, R_CTRL), 32'h01, 4'h1, a);
    check("ind_ch1_kept", 32'(irq), 32'h2);
    check("ind_any_kept", 32'(irq_any), 32'h1);
    wr(ra(1, R_CTRL), 32'h01, 4'h1, a);
    check("ind_any_clr", 32'(irq_any), 32'h0);

    // EN cleared mid-run on a non-tick edge: COUNT frozen, GO reads 0
    wr(ra(0, R_LOAD), 32'h80, 4'hF, a);
    wr(ra(0, R_PRESC), 32'h1, 4'hF, a);
    wr(ra(0, R_CTRL), 32'h06, 4'h1, t);
    wait_until(t + 5);
    wr(ra(0, R_CTRL), 32'h02, 4'h1, a);
    rd_check(ra(0, R_CTRL), 32'h00, "en_clr_go0");
    rd_check(ra(0, R_COUNT), 32'h82, "en_clr_cnt");
    repeat (5) step();
    rd_check(ra(0, R_COUNT), 32'h82, "en_clr_frozen");

    // LOAD written while running applies only at the next reload
    wr(ra(0, R_LOAD), 32'hFE, 4'hF, a);
    wr(ra(0, R_PRESC), 32'h3, 4'hF, a);
    wr(ra(0, R_CTRL), 32'h1E, 4'h1, t);
    wr(ra(0, R_LOAD), 32'hF0, 4'hF, a);
    rd_check(ra(0, R_COUNT), 32'hFE, "ld_run_no_effect");
    rd_check(ra(0, R_COUNT), 32'hFF, "ld_run_tick");
    wait_until(t + 9);
    rd_check(ra(0, R_COUNT), 32'hF0, "ld_run_reload");
    check("ld_run_irq", 32'(irq), 32'h1);

    // Asynchronous reset between clock edges
    #2;
    reset = 1'b1;
    #1;
    check("arst_irq", 32'(irq), 32'h0);
    check("arst_irq_any", 32'(irq_any), 32'h0);
    check("arst_ready", 32'(mem_ready), 32'h0);
    check("arst_rdata", mem_rdata, 32'h0);
    #2;
    reset = 1'b0;
    step();
    rd_check(ra(0, R_CTRL), 32'h0, "arst_ctrl");
    rd_check(ra(0, R_COUNT), 32'h0, "arst_count");

    // Outside the decode window: no acknowledge
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h20;
    for (int i = 0; i < 5; i++) begin
      step();
      check("win_above", 32'(mem_ready), 32'h0);
    end
    mem_addr = BASE - 32'h4;
    for (int i = 0; i < 2; i++) begin
      step();
      check("win_below", 32'(mem_ready), 32'h0);
    end
    mem_valid = 1'b0;
    step();

    // Byte strobes
    wr(ra(1, R_LOAD), 32'h5A, 4'hF, a);
    wr(ra(1, R_LOAD), 32'h0000_3CC3, 4'b0010, a);
    rd_check(ra(1, R_LOAD), 32'h5A, "strb_load_lane1");
    wr(ra(1, R_PRESC), 32'h1234, 4'hF, a);
    wr(ra(1, R_PRESC), 32'hABCD, 4'b0010, a);
    rd_check(ra(1, R_PRESC), 32'hAB34, "strb_presc_lane1");
    wr(ra(1, R_CTRL), 32'h14, 4'b0010, a);
    rd_check(ra(1, R_CTRL), 32'h0, "strb_ctrl_lane0_only");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
